wb_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single 8-bit Wishbone slave bus between
//  NUM_MASTERS requesters (aux protocol bridge, synth sequencer, test master).

---
 rtl/wb_bus_arbiter_if.sv | 43 ++++
 rtl/wb_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// Shared Wishbone bus bundle between the masters, the round-robin arbiter and
// the slave fabric. The arbiter takes the slave modport; the environment takes master.
interface wb_bus_arbiter_if #(
    parameter int NUM_MASTERS   = 3,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1
);
    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i;
    logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i;
    logic [NUM_MASTERS*3-1:0]             m_cti_i;
    logic [NUM_MASTERS-1:0]               m_gnt_o;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic [DATA_WIDTH-1:0]                m_dat_o;
    logic                                 s_cyc_o;
    logic                                 s_stb_o;
    logic                                 s_we_o;
    logic [ADDRESS_WIDTH-1:0]             s_adr_o;
    logic [DATA_WIDTH-1:0]                s_dat_o;
    logic [DATA_BYTES-1:0]                s_sel_o;
    logic [2:0]                           s_cti_o;
    logic [DATA_WIDTH-1:0]                s_dat_i;
    logic                                 s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i,
        input  s_dat_i, s_ack_i,
        output m_gnt_o, m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i,
        output s_dat_i, s_ack_i,
        input  m_gnt_o, m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave bus among NUM_MASTERS masters,
// with a stall watchdog that frees the bus when a slave never acks.
module wb_bus_arbiter #(
    parameter int NUM_MASTERS   = 3,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int MAX_WAIT      = 16
) (
    input logic             clk_i,
    input logic             rst_ni,
    wb_bus_arbiter_if.slave bus
);
    localparam int OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WAIT_W  = $clog2(MAX_WAIT);
    localparam logic [OWNER_W-1:0] LAST_AT_RESET = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT    = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                   state;
    logic [OWNER_W-1:0]       owner;
    logic [OWNER_W-1:0]       last_owner;
    logic [WAIT_W-1:0]        wait_cnt;
    logic [NUM_MASTERS-1:0]   gnt_q;
    logic [NUM_MASTERS-1:0]   err_q;
    logic [OWNER_W-1:0]       rr_winner;

    logic                     owner_cyc;
    logic                     owner_stb;
    logic                     owner_we;
    logic [ADDRESS_WIDTH-1:0] owner_adr;
    logic [DATA_WIDTH-1:0]    owner_dat;
    logic [DATA_BYTES-1:0]    owner_sel;
    logic [2:0]               owner_cti;
    logic                     slave_stb;
    logic [NUM_MASTERS-1:0]   ack_route;

    // First requester at offset 1, 2, ... N from the last owner; scanning the
    // offsets backwards lets the smallest offset overwrite the others.
    function automatic logic [OWNER_W-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [OWNER_W-1:0]     last
    );
        logic [OWNER_W-1:0] pick;
        pick = last;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (req[k] && (k == (int'(last) + off) % NUM_MASTERS)) begin
                    pick = OWNER_W'(k);
                end
            end
        end
        return pick;
    endfunction

    assign rr_winner = rr_pick(bus.m_cyc_i, last_owner);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_we  = 1'b0;
        owner_adr = '0;
        owner_dat = '0;
        owner_sel = '0;
        owner_cti = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (state == GRANT && owner == OWNER_W'(k)) begin
                owner_cyc = bus.m_cyc_i[k];
                owner_stb = bus.m_stb_i[k];
                owner_we  = bus.m_we_i[k];
                owner_adr = bus.m_adr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                owner_dat = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                owner_sel = bus.m_sel_i[k*DATA_BYTES +: DATA_BYTES];
                owner_cti = bus.m_cti_i[k*3 +: 3];
            end
        end
    end

    assign slave_stb = owner_cyc & owner_stb;

    // Acks pass straight through to the owner only, adding no latency.
    always_comb begin
        ack_route = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            ack_route[k] = bus.s_ack_i & slave_stb & (owner == OWNER_W'(k));
        end
    end

    assign bus.s_cyc_o = owner_cyc;
    assign bus.s_stb_o = slave_stb;
    assign bus.s_we_o  = owner_we;
    assign bus.s_adr_o = owner_adr;
    assign bus.s_dat_o = owner_dat;
    assign bus.s_sel_o = owner_sel;
    assign bus.s_cti_o = owner_cti;
    assign bus.m_ack_o = ack_route;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_gnt_o = gnt_q;
    assign bus.m_err_o = err_q;

    // Bus outputs are decoded from state, so the async reset clears them at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_AT_RESET;
            wait_cnt   <= '0;
            gnt_q      <= '0;
            err_q      <= '0;
        end else begin
            err_q <= '0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (|bus.m_cyc_i) begin
                        owner <= rr_winner;
                        gnt_q <= NUM_MASTERS'(1) << rr_winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_cyc) begin
                        state      <= IDLE;
                        gnt_q      <= '0;
                        last_owner <= owner;
                        wait_cnt   <= '0;
                    end else if (slave_stb && !bus.s_ack_i) begin
                        if (wait_cnt == WAIT_LIMIT) begin
                            // Stalled slave: flag the owner and let it re-compete.
                            err_q      <= gnt_q;
                            state      <= IDLE;
                            gnt_q      <= '0;
                            last_owner <= owner;
                            wait_cnt   <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed scenarios plus random traffic for wb_bus_arbiter, checked every cycle
// against an ownership/stall-count model of the arbitration rules.
module tb_wb_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DB = 1;
    localparam int MW = 16;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    wb_bus_arbiter_if #(.NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                        .DATA_BYTES(DB)) bus ();

    wb_bus_arbiter #(.NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                     .DATA_BYTES(DB), .MAX_WAIT(MW)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: who owns the bus (-1 = nobody), who owned it last, stalled cycles.
    int         own;
    int         last;
    int         stall;
    logic [N-1:0] err_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own     = -1;
        last    = N - 1;
        stall   = 0;
        err_exp = '0;
    endtask

    task automatic clear_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_cti_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
    endtask

    // Compare every output at the falling edge against the model's prediction.
    task automatic sample(input string tag);
        logic [N-1:0]  gnt_e, ack_e;
        logic          cyc_e, stb_e, we_e;
        logic [AW-1:0] adr_e;
        logic [DW-1:0] dat_e;
        logic [DB-1:0] sel_e;
        logic [2:0]    cti_e;
        @(negedge clk_i);
        gnt_e = '0; ack_e = '0; cyc_e = 1'b0; stb_e = 1'b0; we_e = 1'b0;
        adr_e = '0; dat_e = '0; sel_e = '0; cti_e = '0;
        if (own >= 0) begin
            gnt_e[own] = 1'b1;
            cyc_e      = bus.m_cyc_i[own];
            stb_e      = cyc_e & bus.m_stb_i[own];
            we_e       = bus.m_we_i[own];
            adr_e      = bus.m_adr_i[own*AW +: AW];
            dat_e      = bus.m_dat_i[own*DW +: DW];
            sel_e      = bus.m_sel_i[own*DB +: DB];
            cti_e      = bus.m_cti_i[own*3 +: 3];
            ack_e[own] = stb_e & bus.s_ack_i;
        end
        chk({tag, ".gnt"}, 32'(bus.m_gnt_o), 32'(gnt_e));
        chk({tag, ".err"}, 32'(bus.m_err_o), 32'(err_exp));
        chk({tag, ".ack"}, 32'(bus.m_ack_o), 32'(ack_e));
        chk({tag, ".scyc"}, 32'(bus.s_cyc_o), 32'(cyc_e));
        chk({tag, ".sstb"}, 32'(bus.s_stb_o), 32'(stb_e));
        chk({tag, ".swe"}, 32'(bus.s_we_o), 32'(we_e));
        chk({tag, ".sadr"}, 32'(bus.s_adr_o), 32'(adr_e));
        chk({tag, ".sdat"}, 32'(bus.s_dat_o), 32'(dat_e));
        chk({tag, ".ssel"}, 32'(bus.s_sel_o), 32'(sel_e));
        chk({tag, ".scti"}, 32'(bus.s_cti_o), 32'(cti_e));
        chk({tag, ".mdat"}, 32'(bus.m_dat_o), 32'(bus.s_dat_i));
    endtask

    // Apply the arbitration rules to this cycle's inputs, then cross the edge.
    task automatic next();
        logic [N-1:0] err_n;
        err_n = '0;
        if (own < 0) begin
            stall = 0;
            for (int off = 1; off <= N; off++) begin
                if (own < 0 && bus.m_cyc_i[(last + off) % N]) own = (last + off) % N;
            end
        end else if (!bus.m_cyc_i[own]) begin
            last  = own;
            own   = -1;
            stall = 0;
        end else if (bus.m_stb_i[own] && !bus.s_ack_i) begin
            stall++;
            if (stall == MW) begin
                err_n[own] = 1'b1;
                last  = own;
                own   = -1;
                stall = 0;
            end
        end else begin
            stall = 0;
        end
        err_exp = err_n;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.gnt", 32'(bus.m_gnt_o), 32'h0);
        chk("rst.err", 32'(bus.m_err_o), 32'h0);
        chk("rst.scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst.sstb", 32'(bus.s_stb_o), 32'h0);
        chk("rst.ack", 32'(bus.m_ack_o), 32'h0);
        rst_ni = 1'b1;

        // 1: single write by master 0
        bus.m_cyc_i = 3'b001; bus.m_stb_i = 3'b001; bus.m_we_i = 3'b001;
        bus.m_adr_i[0 +: AW] = 16'h0000; bus.m_dat_i[0 +: DW] = 8'h15;
        sample("t1.idle"); chk("t1.idle_gnt", 32'(bus.m_gnt_o), 32'h0); next();
        sample("t1.gnt");
        chk("t1.gnt1", 32'(bus.m_gnt_o), 32'b001);
        chk("t1.adr", 32'(bus.s_adr_o), 32'h0000);
        chk("t1.dat", 32'(bus.s_dat_o), 32'h15);
        chk("t1.we", 32'(bus.s_we_o), 32'h1);
        next();
        bus.s_ack_i = 1'b1;
        sample("t1.ack"); chk("t1.ack1", 32'(bus.m_ack_o), 32'b001); next();
        clear_inputs();
        sample("t1.drop"); next();
        sample("t1.end"); chk("t1.gnt0", 32'(bus.m_gnt_o), 32'h0); next();

        // 2: all three request continuously, one access each
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.m_cyc_i = 3'b111; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
            sample("t2.idle"); chk("t2.idle_gnt", 32'(bus.m_gnt_o), 32'h0); next();
            bus.m_stb_i = 3'(1 << (i % 3)); bus.s_ack_i = 1'b1;
            sample("t2.acc");
            chk("t2.gnt", 32'(bus.m_gnt_o), 32'(1 << (i % 3)));
            chk("t2.ack", 32'(bus.m_ack_o), 32'(1 << (i % 3)));
            next();
            bus.m_cyc_i = 3'(~(1 << (i % 3))); bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
            sample("t2.drop"); next();
        end

        // 3: master 1 owns, master 0 waits
        bus.m_cyc_i = 3'b010; bus.m_stb_i = '0;
        sample("t3.idle"); next();
        bus.m_cyc_i = 3'b011;
        for (int i = 0; i < 6; i++) begin
            bus.m_stb_i = 3'b010; bus.s_ack_i = i[0];
            sample("t3.own");
            chk("t3.gnt", 32'(bus.m_gnt_o), 32'b010);
            chk("t3.ack0", 32'(bus.m_ack_o[0]), 32'h0);
            next();
        end
        bus.m_cyc_i = 3'b001; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
        sample("t3.drop"); next();
        sample("t3.idle2"); next();
        sample("t3.hand"); chk("t3.gnt0", 32'(bus.m_gnt_o), 32'b001);
        next();

        // 4: master 2 stalls until the watchdog releases it
        bus.m_cyc_i = '0;
        sample("t4.drop"); next();
        bus.m_cyc_i = 3'b100; bus.m_stb_i = 3'b100; bus.m_adr_i[2*AW +: AW] = 16'h0100;
        sample("t4.idle"); next();
        for (int i = 0; i < MW; i++) begin
            sample("t4.stall");
            chk("t4.gnt", 32'(bus.m_gnt_o), 32'b100);
            chk("t4.adr", 32'(bus.s_adr_o), 32'h0100);
            chk("t4.noerr", 32'(bus.m_err_o), 32'h0);
            next();
        end
        sample("t4.wd");
        chk("t4.err", 32'(bus.m_err_o), 32'b100);
        chk("t4.gnt0", 32'(bus.m_gnt_o), 32'h0);
        chk("t4.scyc", 32'(bus.s_cyc_o), 32'h0);
        next();

        // 5: ack arrives exactly at the watchdog limit
        sample("t5.regnt");
        chk("t5.err0", 32'(bus.m_err_o), 32'h0);
        chk("t5.gnt", 32'(bus.m_gnt_o), 32'b100);
        next();
        for (int i = 0; i < MW - 2; i++) begin
            sample("t5.stall"); chk("t5.noerr", 32'(bus.m_err_o), 32'h0); next();
        end
        bus.s_ack_i = 1'b1;
        sample("t5.lim"); chk("t5.ack", 32'(bus.m_ack_o), 32'b100); next();
        bus.s_ack_i = 1'b0;
        sample("t5.after");
        chk("t5.noerr2", 32'(bus.m_err_o), 32'h0);
        chk("t5.kept", 32'(bus.m_gnt_o), 32'b100);
        next();

        // 6: asynchronous reset in the middle of a write by master 1
        clear_inputs();
        sample("t6.drop"); next();
        bus.m_cyc_i = 3'b010; bus.m_stb_i = 3'b010; bus.m_we_i = 3'b010;
        bus.m_adr_i[AW +: AW] = 16'h0042; bus.m_dat_i[DW +: DW] = 8'h5a;
        sample("t6.idle"); next();
        sample("t6.own"); chk("t6.gnt", 32'(bus.m_gnt_o), 32'b010);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6.scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("t6.sstb", 32'(bus.s_stb_o), 32'h0);
        chk("t6.gnt0", 32'(bus.m_gnt_o), 32'h0);
        model_reset();
        bus.m_cyc_i = 3'b011;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sample("t6.idle2"); next();
        sample("t6.first"); chk("t6.gnt_m0", 32'(bus.m_gnt_o), 32'b001); next();

        // Random traffic; rare acks let the watchdog fire now and then
        clear_inputs();
        for (int i = 0; i < 2500; i++) begin
            bus.m_cyc_i = N'($urandom | $urandom);
            bus.m_stb_i = N'($urandom | $urandom);
            bus.m_we_i  = N'($urandom);
            bus.m_adr_i = (N*AW)'({$urandom, $urandom});
            bus.m_dat_i = (N*DW)'($urandom);
            bus.m_sel_i = (N*DB)'($urandom);
            bus.m_cti_i = (N*3)'($urandom);
            bus.s_dat_i = DW'($urandom);
            bus.s_ack_i = ($urandom_range(0, 7) == 0);
            sample("rnd");
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
